// File: rtl/seq_shifter_pkg.sv
// Shared types and encodings for the sequential shifter.
// Optional rotate support is enabled with the SEQ_SHIFTER_ROTATE_EN macro.
package seq_shifter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic DIR_RIGHT  = 1'b0;
  localparam logic DIR_LEFT   = 1'b1;
  localparam logic FILL_LOGIC = 1'b0;
  localparam logic FILL_ARITH = 1'b1;

endpackage

// File: rtl/seq_shifter_shift1_step.sv
// One-position shift/rotate stage; purely combinational.
// The rot input exists only when SEQ_SHIFTER_ROTATE_EN is defined.
module shift1_step
  import seq_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             lr,
  input  logic             al,
`ifdef SEQ_SHIFTER_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] shifted
);

  // Select the single-bit move; the fill bit comes from the current MSB for arithmetic right.
  always_comb begin
    shifted = data;
    if (lr == DIR_LEFT) begin
      shifted = {data[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {((al == FILL_ARITH) ? data[WIDTH-1] : 1'b0), data[WIDTH-1:1]};
    end
`ifdef SEQ_SHIFTER_ROTATE_EN
    if (rot) begin
      if (lr == DIR_LEFT) begin
        shifted = {data[WIDTH-2:0], data[WIDTH-1]};
      end else begin
        shifted = {data[0], data[WIDTH-1:1]};
      end
    end
`endif
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle barrel shifter: one bit position per clock under valid/ready.
// Define SEQ_SHIFTER_ROTATE_EN to add the ROT input (rotate instead of shift).
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  input  logic             LR,
  input  logic             AL,
`ifdef SEQ_SHIFTER_ROTATE_EN
  input  logic             ROT,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             lr_q, lr_d;
  logic             al_q, al_d;
  logic [WIDTH-1:0] dout_d;
  logic [WIDTH-1:0] step;
`ifdef SEQ_SHIFTER_ROTATE_EN
  logic             rot_q, rot_d;
`endif

  shift1_step #(.WIDTH(WIDTH)) u_step (
    .data    (data_q),
    .lr      (lr_q),
    .al      (al_q),
`ifdef SEQ_SHIFTER_ROTATE_EN
    .rot     (rot_q),
`endif
    .shifted (step)
  );

  // Next-state and datapath decode; dout is loaded on the transition into DONE.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    lr_d    = lr_q;
    al_d    = al_q;
    dout_d  = dout;
`ifdef SEQ_SHIFTER_ROTATE_EN
    rot_d   = rot_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d = din;
          cnt_d  = shamt;
          lr_d   = LR;
          al_d   = AL;
`ifdef SEQ_SHIFTER_ROTATE_EN
          rot_d  = ROT;
`endif
          if (shamt == SHW'(0)) begin
            state_d = S_DONE;
            dout_d  = din;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        data_d = step;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = S_DONE;
          dout_d  = step;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      cnt_q     <= '0;
      lr_q      <= 1'b0;
      al_q      <= 1'b0;
`ifdef SEQ_SHIFTER_ROTATE_EN
      rot_q     <= 1'b0;
`endif
      dout      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      lr_q      <= lr_d;
      al_q      <= al_d;
`ifdef SEQ_SHIFTER_ROTATE_EN
      rot_q     <= rot_d;
`endif
      dout      <= dout_d;
      in_ready  <= (state_d == S_IDLE);
      out_valid <= (state_d == S_DONE);
      busy      <= (state_d != S_IDLE);
    end
  end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
Multi-cycle counterpart of the combinational 8-bit barrel shifter. It shifts one bit position per clock under a valid/ready handshake.
- Accepts an operand, shift amount, direction (LR) and fill mode (AL).
- Iterates a 1-bit shift stage for shamt cycles.
- Presents the result on a held output handshake.
- Its results must match the combinational shifter bit-for-bit; it serves as the area-cheap shift path in the lab datapath.

Parameters:
WIDTH, 8, operand/result width in bits
SHW, $clog2(WIDTH) = 3, shift-amount width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand offered
in_ready  out  1  block can accept operand (high only in IDLE)
din  in  WIDTH  operand
shamt  in  SHW  shift distance 0..WIDTH-1
LR  in  1  1 = left shift, 0 = right shift
AL  in  1  right shift only: 1 = arithmetic (fill din[MSB]), 0 = logical (fill 0); ignored for left
out_valid  out  1  result available
out_ready  in  1  consumer takes result
dout  out  WIDTH  result
busy  out  1  high in SHIFT or DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, dout=0, internal data/count/mode registers=0.
  - Outputs: out_valid=0, busy=0, in_ready=1.
  - Takes effect immediately, including mid-SHIFT or in DONE; the pending operation is discarded.
- States: IDLE, SHIFT, DONE. Outputs decode from state: in_ready=(IDLE), out_valid=(DONE), busy=!(IDLE).
- IDLE:
  - On in_valid&&in_ready, latch din into data reg, shamt into cnt, and LR/AL into mode regs.
  - If shamt==0, go to DONE; otherwise go to SHIFT.
  - in_valid while not IDLE is ignored and the operand is not captured.
- SHIFT, each edge:
  - Left: data <= {data[WIDTH-2:0],1'b0}.
  - Right logical: data <= {1'b0,data[WIDTH-1:1]}.
  - Right arithmetic: data <= {data[WIDTH-1],data[WIDTH-1:1]}.
  - cnt <= cnt-1.
  - When cnt==1 at the edge, go to DONE.
- Latency: out_valid rises on the edge shamt cycles after the accepting edge; for shamt=0 it rises on the accepting edge itself. Minimum 1 cycle, maximum WIDTH-1 cycles, from accept to out_valid visible.
- DONE:
  - dout = data; it is registered and stable for as long as out_valid=1.
  - On out_ready=1, return to IDLE; in_ready is high the following cycle. There is no same-cycle re-accept.
  - out_ready while not in DONE is ignored.
- Mode is captured at accept. Changes on LR/AL/shamt/din during SHIFT have no effect.
- Arithmetic fill uses the current data MSB each step, which equals the original sign bit.
- Throughput: one operation per shamt+2 cycles with out_ready tied high.

Optional Feature:
- Macro SEQ_SHIFTER_ROTATE_EN.
- Defined:
  - Adds input port ROT (1 bit), captured at accept.
  - ROT=1 rotates instead of shifting: left data <= {data[WIDTH-2:0],data[WIDTH-1]}; right data <= {data[0],data[WIDTH-1:1]}. AL is ignored.
  - ROT=0 behaves as the base block.
- Undefined: no ROT port; only shifts are supported.

Decomposition:
- Package seq_shifter_pkg:
  - State enum {S_IDLE,S_SHIFT,S_DONE}.
  - DIR_RIGHT=1'b0, DIR_LEFT=1'b1, FILL_LOGIC=1'b0, FILL_ARITH=1'b1.
- One combinational sub-module, shift1_step: data, LR, AL (and ROT when enabled) in; one-position shifted data out. The FSM instantiates it once, and the bench reuses it as the reference stage.

Test Plan:
- Left shift: din=8'b1001_0110, shamt=3, LR=1 -> dout=8'b1011_0000; out_valid 3 cycles after accept; busy high throughout.
- Right arithmetic vs logical: din=8'hA5, shamt=2, LR=0. AL=1 -> 8'hE9; AL=0 -> 8'h29. Also din=8'h80, shamt=7, AL=1 -> 8'hFF.
- Zero shift: din=8'h3C, shamt=0 -> dout=8'h3C, out_valid on the cycle after accept.
- Backpressure: out_ready held low 5 cycles in DONE -> dout and out_valid stable. A new in_valid with din=8'h11 is not accepted; in_ready rises one cycle after out_ready.
- Reset mid-operation: rst_n low during the 2nd SHIFT cycle of shamt=5 -> out_valid=0, dout=0, busy=0, in_ready=1 immediately. The next operation with din=8'h01, shamt=1, LR=1 gives 8'h02.
- With SEQ_SHIFTER_ROTATE_EN: din=8'h81, shamt=1, LR=1, ROT=1 -> 8'h03; LR=0 -> 8'hC0.
